clock_adjust_ctrl: RTL
======================

Name: clock_adjust_ctrl

Overview:
- Time-set controller for the 24-hour clock datapath (seconds/minutes/hours counters).
- Decodes the debounced MODE/SELECT/ADJUST buttons into edge events and sequences an adjust state machine.
- Issues single-cycle SECCLR/MININC/HOURINC pulses to the counters, with auto-repeat on a held ADJUST.
- Returns to normal display after inactivity and drives the per-field blink enables.

Parameters:
- CW, 12, width of the tick counters. Must hold TIMEOUT.
- REPEAT_DLY, 50, CE ticks from the ADJUST press to the first auto-repeat pulse (0.5 s at 100 Hz CE).
- REPEAT_PER, 10, CE ticks between subsequent auto-repeat pulses (0.1 s).
- TIMEOUT, 3000, CE ticks without activity before an adjust state returns to NORM (30 s).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- CE  in  1  one-cycle tick enable, nominally 100 Hz.
- SIG2HZ  in  1  2 Hz blink square wave.
- MODE  in  1  debounced level, active-high.
- SELECT  in  1  debounced level, active-high.
- ADJUST  in  1  debounced level, active-high.
- SECCLR  out  1  one-cycle pulse: clear seconds.
- MININC  out  1  one-cycle pulse: increment minutes.
- HOURINC  out  1  one-cycle pulse: increment hours.
- SECON  out  1  seconds digit enable (0 = blanked).
- MINON  out  1  minutes digit enable (0 = blanked).
- HOURON  out  1  hours digit enable (0 = blanked).
- ADJMODE  out  1  high when the state is not NORM.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge CLK.
  - RST has priority over everything.
- Reset values:
  - State = NORM; repeat and timeout counters = 0.
  - SECCLR/MININC/HOURINC = 0; ADJMODE = 0; SECON/MINON/HOURON = 1.
  - Button history registers reset to 1, so a button held through reset produces no edge.
- Edge detect: an event is input = 1 while the history register = 0. History registers update every cycle.
- States: NORM, SEC, MIN, HOUR.
- Transitions, one per cycle, priority MODE > SELECT > ADJUST:
  - MODE event: NORM -> SEC; SEC/MIN/HOUR -> NORM.
  - SELECT event, adjust states only: SEC -> HOUR -> MIN -> SEC. Ignored in NORM.
- ADJUST pulses:
  - An ADJUST event in SEC/MIN/HOUR, with no MODE/SELECT event in the same cycle, asserts the matching pulse (SEC->SECCLR, MIN->MININC, HOUR->HOURINC).
  - Pulses are registered outputs: high for exactly one cycle, the cycle after the event. Latency 1.
  - ADJUST is ignored in NORM. At most one pulse output is high in any cycle.
- Auto-repeat, MIN and HOUR only:
  - While ADJUST stays high after its event, the repeat counter increments on CE.
  - On reaching REPEAT_DLY, a pulse is emitted and the counter reloads so the next pulse follows REPEAT_PER CE ticks later; repeats continue until release.
  - The counter clears on ADJUST low, on any state change, and in SEC/NORM. SEC never auto-repeats.
- Timeout:
  - In adjust states the timeout counter increments on CE.
  - It clears on any MODE/SELECT/ADJUST event, on any auto-repeat pulse, and on entry to an adjust state.
  - Reaching TIMEOUT forces NORM next cycle; no pulse is issued that cycle.
  - The counter is held at 0 in NORM.
- Simultaneous events:
  - A MODE or SELECT event coinciding with an ADJUST event or a repeat expiry: the state change wins and no pulse is issued.
  - Timeout coinciding with a button event: the event wins and timeout clears.
- Blink outputs (combinational from state, SIG2HZ, ADJUST):
  - SECON = ~(state==SEC & SIG2HZ & ~ADJUST). MINON and HOURON follow the same form for MIN and HOUR.
  - Digits are solid while ADJUST is held.
- ADJMODE = (state != NORM), registered with the state.
- Reset mid-repeat or mid-timeout: everything returns to reset values next cycle; no pulse appears in the cycle after RST.

Test Plan:
- Reset with MODE held high, release, press MODE once -> state SEC (ADJMODE=1) one cycle after the second press; no transition on the first release.
- In SEC press SELECT three times -> states HOUR, MIN, SEC. Press ADJUST in HOUR -> HOURINC high exactly 1 cycle, 1 cycle after the edge; SECCLR/MININC stay 0.
- In MIN hold ADJUST for 80 CE ticks (REPEAT_DLY=50, REPEAT_PER=10) -> MININC count = 1 initial + 1 at tick 50 + 1 at tick 60 + 1 at tick 70 + 1 at tick 80 = 5 pulses. MINON held 1 throughout.
- In SEC hold ADJUST for 200 CE ticks -> exactly 1 SECCLR pulse. Separately, SIG2HZ=1 with ADJUST=0 -> SECON=0.
- Enter HOUR, apply no buttons for 3000 CE ticks -> return to NORM, ADJMODE=0, no pulse. Repeat with an ADJUST press at tick 2999 -> HOURINC pulse; the timeout restarts.
- In MIN assert MODE and ADJUST rising in the same cycle -> state NORM, no MININC. Assert RST during a held-ADJUST repeat -> NORM with all pulses 0 the next cycle.

Source files
------------

// File: rtl/clock_adjust_ctrl.sv
// Time-set controller for the 24-hour clock: button edge decode, adjust FSM,
// single-cycle counter pulses with auto-repeat, inactivity timeout and blink enables.
module clock_adjust_ctrl #(
  parameter int unsigned CW         = 12,
  parameter int unsigned REPEAT_DLY = 50,
  parameter int unsigned REPEAT_PER = 10,
  parameter int unsigned TIMEOUT    = 3000
) (
  input  logic CLK,
  input  logic RST,
  input  logic CE,
  input  logic SIG2HZ,
  input  logic MODE,
  input  logic SELECT,
  input  logic ADJUST,
  output logic SECCLR,
  output logic MININC,
  output logic HOURINC,
  output logic SECON,
  output logic MINON,
  output logic HOURON,
  output logic ADJMODE
);

  typedef enum logic [1:0] {StNorm, StSec, StMin, StHour} state_e;

  localparam logic [CW-1:0] RepLast   = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] RepReload = CW'(REPEAT_DLY - REPEAT_PER);
  localparam logic [CW-1:0] ToLast    = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] rep_q, rep_d;
  logic [CW-1:0] to_q, to_d;
  logic          rep_arm_q, rep_arm_d;
  logic          mode_hist_q, sel_hist_q, adj_hist_q;
  logic          secclr_q, secclr_d;
  logic          mininc_q, mininc_d;
  logic          hourinc_q, hourinc_d;
  logic          adjmode_q, adjmode_d;

  logic mode_ev, sel_ev, adj_ev;
  logic in_adj, rep_state, rep_hit, to_hit;

  assign mode_ev   = MODE & ~mode_hist_q;
  assign sel_ev    = SELECT & ~sel_hist_q;
  assign adj_ev    = ADJUST & ~adj_hist_q;
  assign in_adj    = (state_q != StNorm);
  assign rep_state = (state_q == StMin) || (state_q == StHour);
  assign rep_hit   = rep_state & rep_arm_q & ADJUST & CE & (rep_q == RepLast);
  assign to_hit    = in_adj & CE & (to_q == ToLast);

  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    rep_arm_d = rep_arm_q;
    to_d      = to_q;
    secclr_d  = 1'b0;
    mininc_d  = 1'b0;
    hourinc_d = 1'b0;

    if (!in_adj) begin
      if (mode_ev) state_d = StSec;
      to_d      = '0;
      rep_d     = '0;
      rep_arm_d = 1'b0;
    end else if (mode_ev || sel_ev) begin
      // A state change always beats a coincident adjust event or repeat expiry.
      if (mode_ev) begin
        state_d = StNorm;
      end else begin
        unique case (state_q)
          StSec:   state_d = StHour;
          StHour:  state_d = StMin;
          StMin:   state_d = StSec;
          default: state_d = StNorm;
        endcase
      end
      to_d      = '0;
      rep_d     = '0;
      rep_arm_d = 1'b0;
    end else if (adj_ev) begin
      unique case (state_q)
        StSec:   secclr_d  = 1'b1;
        StMin:   mininc_d  = 1'b1;
        StHour:  hourinc_d = 1'b1;
        default: ;
      endcase
      to_d      = '0;
      rep_d     = '0;
      rep_arm_d = rep_state;
    end else if (rep_hit) begin
      if (state_q == StMin) mininc_d = 1'b1;
      else                  hourinc_d = 1'b1;
      rep_d = RepReload;
      to_d  = '0;
    end else if (to_hit) begin
      state_d   = StNorm;
      to_d      = '0;
      rep_d     = '0;
      rep_arm_d = 1'b0;
    end else begin
      if (CE) to_d = to_q + CW'(1);
      if (!ADJUST) begin
        rep_d     = '0;
        rep_arm_d = 1'b0;
      end else if (rep_arm_q && CE) begin
        rep_d = rep_q + CW'(1);
      end
    end

    adjmode_d = (state_d != StNorm);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StNorm;
      rep_q       <= '0;
      to_q        <= '0;
      rep_arm_q   <= 1'b0;
      // History resets high so a button held through reset yields no edge.
      mode_hist_q <= 1'b1;
      sel_hist_q  <= 1'b1;
      adj_hist_q  <= 1'b1;
      secclr_q    <= 1'b0;
      mininc_q    <= 1'b0;
      hourinc_q   <= 1'b0;
      adjmode_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rep_q       <= rep_d;
      to_q        <= to_d;
      rep_arm_q   <= rep_arm_d;
      mode_hist_q <= MODE;
      sel_hist_q  <= SELECT;
      adj_hist_q  <= ADJUST;
      secclr_q    <= secclr_d;
      mininc_q    <= mininc_d;
      hourinc_q   <= hourinc_d;
      adjmode_q   <= adjmode_d;
    end
  end

  assign SECCLR  = secclr_q;
  assign MININC  = mininc_q;
  assign HOURINC = hourinc_q;
  assign ADJMODE = adjmode_q;

  assign SECON  = ~((state_q == StSec)  & SIG2HZ & ~ADJUST);
  assign MINON  = ~((state_q == StMin)  & SIG2HZ & ~ADJUST);
  assign HOURON = ~((state_q == StHour) & SIG2HZ & ~ADJUST);

endmodule
